// File: rtl/updown_dir_ctrl.sv
// ---------------------------------------------------------------------------
// updown_dir_ctrl
//
// Direction controller for an external up/down counter. It watches the
// counter value and drives the counter's ud input. Supported modes are
// up-only, down-only, bounce between two limits, and hold. In bounce mode
// it counts reversals and flags limit settings that cannot work.
//
// Ports
//   clk     : single clock, rising edge
//   rst     : asynchronous, active-high reset
//   en      : run enable; low parks the controller in IDLE
//   mode    : 00 up-only, 01 down-only, 10 bounce, 11 hold
//   cnt_in  : current value of the downstream counter
//   lo, hi  : lower / upper bounce limits (unsigned)
//   clr     : synchronous clear of rev_cnt (wins over an increment)
//   ud      : registered direction to the counter, 0 = up, 1 = down
//   turn    : registered one-cycle pulse on each bounce reversal
//   rev_cnt : registered count of reversals, saturates at 255
//   err     : registered flag, bounce requested with lo >= hi
// ---------------------------------------------------------------------------
module updown_dir_ctrl #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [1:0]   mode,
  input  logic [N-1:0] cnt_in,
  input  logic [N-1:0] lo,
  input  logic [N-1:0] hi,
  input  logic         clr,
  output logic         ud,
  output logic         turn,
  output logic [7:0]   rev_cnt,
  output logic         err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_t;

  state_t state;
  // Set while a bounce run is in progress. It separates "first bounce edge"
  // (choose a direction, no pulse) from "already bouncing" (look-ahead
  // reversal). A plain UP state cannot carry this, because up-only mode also
  // sits in UP.
  logic   bouncing;

  // Limits widened by one bit so hi-1 and lo+1 never wrap. hi = 0 would
  // wrap, but lo >= 0 = hi always raises err, so that value is never used.
  logic [N:0] hi_m1;
  logic [N:0] lo_p1;
  logic       err_cond;
  logic       halt;
  logic       at_top;
  logic       at_bot;
  logic       turn_now;

  assign hi_m1    = {1'b0, hi} - (N+1)'(1);
  assign lo_p1    = {1'b0, lo} + (N+1)'(1);
  assign err_cond = en && (mode == MODE_BOUNCE) && (lo >= hi);
  assign halt     = !en || (mode == MODE_HOLD) || err_cond;

  // The counter samples ud on the same edge that we do. Reversing one step
  // early therefore makes the counter peak exactly at hi and bottom at lo.
  assign at_top   = {1'b0, cnt_in} >= hi_m1;
  assign at_bot   = {1'b0, cnt_in} <= lo_p1;
  assign turn_now = !halt && (mode == MODE_BOUNCE) && bouncing &&
                    ((state == UP) ? at_top : at_bot);

  // NOTE: every register here, state included, is written with non-blocking
  // assignments and reset asynchronously, so all readers see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bouncing <= 1'b0;
      ud       <= 1'b0;
      turn     <= 1'b0;
      rev_cnt  <= 8'd0;
      err      <= 1'b0;
    end else begin
      err  <= err_cond;
      turn <= turn_now;

      if (clr)
        rev_cnt <= 8'd0;
      else if (turn_now && (rev_cnt != 8'hFF))
        rev_cnt <= rev_cnt + 8'd1;

      if (halt) begin
        // ud is left alone, so the counter keeps its last direction.
        state    <= IDLE;
        bouncing <= 1'b0;
      end else begin
        case (mode)
          MODE_UP: begin
            state    <= UP;
            ud       <= 1'b0;
            bouncing <= 1'b0;
          end
          MODE_DOWN: begin
            state    <= DOWN;
            ud       <= 1'b1;
            bouncing <= 1'b0;
          end
          default: begin
            // Bounce. MODE_HOLD never reaches here because halt covers it.
            bouncing <= 1'b1;
            if (!bouncing) begin
              if (cnt_in < hi) begin
                state <= UP;
                ud    <= 1'b0;
              end else begin
                state <= DOWN;
                ud    <= 1'b1;
              end
            end else if (turn_now) begin
              if (state == UP) begin
                state <= DOWN;
                ud    <= 1'b1;
              end else begin
                state <= UP;
                ud    <= 1'b0;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_updown_dir_ctrl.sv
// ---------------------------------------------------------------------------
// tb_updown_dir_ctrl
//
// Directed bench for updown_dir_ctrl with N = 4. An up/down counter model
// closes the loop: it steps on every rising edge using the ud value from
// before that edge. Each scenario task sets inputs on the falling edge and
// checks outputs on a later falling edge against hand-derived values.
// ---------------------------------------------------------------------------
module tb_updown_dir_ctrl;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [1:0]   mode;
  logic [N-1:0] cnt;
  logic [N-1:0] lo;
  logic [N-1:0] hi;
  logic         clr;
  logic         ud;
  logic         turn;
  logic [7:0]   rev_cnt;
  logic         err;

  // Controls for the counter model.
  logic         cnt_run;
  logic         cnt_load;
  logic [N-1:0] load_val;

  int n_cmp = 0;
  int n_bad = 0;

  updown_dir_ctrl #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .cnt_in  (cnt),
    .lo      (lo),
    .hi      (hi),
    .clr     (clr),
    .ud      (ud),
    .turn    (turn),
    .rev_cnt (rev_cnt),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Downstream counter. It reads ud from before the edge.
  always @(posedge clk) begin
    if (cnt_load)
      cnt <= load_val;
    else if (cnt_run)
      cnt <= ud ? cnt - 1'b1 : cnt + 1'b1;
  end

  // Advance n rising edges and stop on the following falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic load_cnt(input logic [N-1:0] v);
    cnt_load = 1'b1;
    load_val = v;
    step(1);
    cnt_load = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; mode = 2'b00; clr = 1'b0;
    lo = '0; hi = '0; cnt_run = 1'b0; cnt_load = 1'b0; load_val = '0;
    #1;
    n_cmp++;
    if ({ud, turn, rev_cnt, err} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_async got=%h exp=000", {ud, turn, rev_cnt, err});
    end
    load_cnt(4'd0);
    n_cmp++;
    if ({ud, turn, rev_cnt, err} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_held got=%h exp=000", {ud, turn, rev_cnt, err});
    end
    rst = 1'b0;
    step(1);
    n_cmp++;
    if ({ud, turn, rev_cnt, err} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_release_idle got=%h exp=000", {ud, turn, rev_cnt, err});
    end
  endtask

  // lo=2, hi=12, counter from 0: 0..12, 11..2, 3..12; turns at edges 12, 22, 32.
  task automatic test_bounce;
    logic [N-1:0] exp_cnt;
    logic         exp_ud;
    logic         exp_turn;
    lo = 4'd2; hi = 4'd12; mode = 2'b10; en = 1'b1; cnt_run = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      step(1);
      if (e <= 12) begin
        exp_cnt = 4'(e);      exp_ud = (e == 12); exp_turn = (e == 12);
      end else if (e <= 22) begin
        exp_cnt = 4'(24 - e); exp_ud = (e != 22); exp_turn = (e == 22);
      end else begin
        exp_cnt = 4'(e - 20); exp_ud = (e == 32); exp_turn = (e == 32);
      end
      n_cmp++;
      if ({cnt, ud, turn} !== {exp_cnt, exp_ud, exp_turn}) begin
        n_bad++;
        $display("FAIL bounce_edge%0d got cnt=%0d ud=%b turn=%b exp cnt=%0d ud=%b turn=%b",
                 e, cnt, ud, turn, exp_cnt, exp_ud, exp_turn);
      end
      if (e == 22) begin
        n_cmp++;
        if (rev_cnt !== 8'd2) begin
          n_bad++;
          $display("FAIL bounce_rev_full_cycle got=%0d exp=2", rev_cnt);
        end
      end
    end
    n_cmp++;
    if (rev_cnt !== 8'd3) begin
      n_bad++;
      $display("FAIL bounce_rev_end got=%0d exp=3", rev_cnt);
    end
  endtask

  // Up-only from 10 for 20 edges: wraps 15 -> 0, no turns.
  task automatic test_up_only;
    mode = 2'b00; cnt_run = 1'b0;
    step(1);
    n_cmp++;
    if ({ud, turn} !== 2'b00) begin
      n_bad++;
      $display("FAIL up_switch got ud=%b turn=%b exp ud=0 turn=0", ud, turn);
    end
    load_cnt(4'd10);
    cnt_run = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      n_cmp++;
      if ({cnt, ud, turn} !== {4'((10 + k) % 16), 2'b00}) begin
        n_bad++;
        $display("FAIL up_edge%0d got cnt=%0d ud=%b turn=%b exp cnt=%0d ud=0 turn=0",
                 k, cnt, ud, turn, (10 + k) % 16);
      end
    end
    n_cmp++;
    if (rev_cnt !== 8'd3) begin
      n_bad++;
      $display("FAIL up_rev_unchanged got=%0d exp=3", rev_cnt);
    end
  endtask

  task automatic test_down_only;
    mode = 2'b01; cnt_run = 1'b0;
    step(1);
    n_cmp++;
    if ({ud, turn} !== 2'b10) begin
      n_bad++;
      $display("FAIL down_switch got ud=%b turn=%b exp ud=1 turn=0", ud, turn);
    end
    cnt_run = 1'b1;
    step(3);
    n_cmp++;
    if ({cnt, ud, rev_cnt} !== {4'd11, 1'b1, 8'd3}) begin
      n_bad++;
      $display("FAIL down_run got cnt=%0d ud=%b rev=%0d exp cnt=11 ud=1 rev=3", cnt, ud, rev_cnt);
    end
  endtask

  // Bad limits raise err with ud held. A tight lo+1 == hi window then toggles.
  task automatic test_err_limits;
    cnt_run = 1'b0;
    load_cnt(4'd5);
    mode = 2'b10; lo = 4'd0; hi = 4'd0;
    step(1);
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL err_hi_zero got=%b exp=1", err);
    end
    lo = 4'd9; hi = 4'd9;
    step(1);
    n_cmp++;
    if ({err, ud, turn} !== 3'b110) begin
      n_bad++;
      $display("FAIL err_lo_eq_hi got err=%b ud=%b turn=%b exp err=1 ud=1 turn=0", err, ud, turn);
    end
    hi = 4'd10; cnt_run = 1'b1;
    step(1);
    n_cmp++;
    if ({err, ud, turn, cnt} !== {3'b000, 4'd4}) begin
      n_bad++;
      $display("FAIL err_clear got err=%b ud=%b turn=%b cnt=%0d exp err=0 ud=0 turn=0 cnt=4",
               err, ud, turn, cnt);
    end
    step(5);
    n_cmp++;
    if ({cnt, ud, turn} !== {4'd9, 2'b00}) begin
      n_bad++;
      $display("FAIL tight_climb got cnt=%0d ud=%b turn=%b exp cnt=9 ud=0 turn=0", cnt, ud, turn);
    end
    for (int i = 0; i < 7; i++) begin
      step(1);
      n_cmp++;
      if ({cnt, ud, turn} !== {((i % 2 == 0) ? 4'd10 : 4'd9), (i % 2 == 0), 1'b1}) begin
        n_bad++;
        $display("FAIL tight_toggle%0d got cnt=%0d ud=%b turn=%b exp cnt=%0d ud=%0d turn=1",
                 i, cnt, ud, turn, (i % 2 == 0) ? 10 : 9, (i % 2 == 0));
      end
    end
    n_cmp++;
    if (rev_cnt !== 8'd10) begin
      n_bad++;
      $display("FAIL tight_rev got=%0d exp=10", rev_cnt);
    end
  endtask

  // Window still toggles each cycle, so each edge is a reversal.
  task automatic test_saturate_clr;
    step(245);
    n_cmp++;
    if (rev_cnt !== 8'd255) begin
      n_bad++;
      $display("FAIL sat_reach got=%0d exp=255", rev_cnt);
    end
    step(55);
    n_cmp++;
    if ({rev_cnt, turn} !== {8'd255, 1'b1}) begin
      n_bad++;
      $display("FAIL sat_hold got rev=%0d turn=%b exp rev=255 turn=1", rev_cnt, turn);
    end
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    n_cmp++;
    if ({rev_cnt, turn} !== {8'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL clr_vs_turn got rev=%0d turn=%b exp rev=0 turn=1", rev_cnt, turn);
    end
    step(1);
    n_cmp++;
    if (rev_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL clr_then_count got=%0d exp=1", rev_cnt);
    end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 3 && ud !== 1'b1; i++)
      step(1);
    n_cmp++;
    if (ud !== 1'b1) begin
      n_bad++;
      $display("FAIL areset_wait_down got ud=%b exp=1 within 3 edges", ud);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({ud, turn, rev_cnt, err} !== 11'd0) begin
      n_bad++;
      $display("FAIL areset_immediate got=%h exp=000", {ud, turn, rev_cnt, err});
    end
    @(negedge clk);
    n_cmp++;
    if ({ud, turn, rev_cnt, err} !== 11'd0) begin
      n_bad++;
      $display("FAIL areset_hold got=%h exp=000", {ud, turn, rev_cnt, err});
    end
    rst = 1'b0;
  endtask

  // Pause mid-descent (en=0, then hold), then resume and re-enter bounce.
  task automatic test_pause_resume;
    cnt_run = 1'b0; en = 1'b0;
    load_cnt(4'd0);
    lo = 4'd2; hi = 4'd12; mode = 2'b10; en = 1'b1; cnt_run = 1'b1;
    step(14);
    n_cmp++;
    if ({cnt, ud, turn, rev_cnt} !== {4'd10, 2'b10, 8'd1}) begin
      n_bad++;
      $display("FAIL pause_pre got cnt=%0d ud=%b turn=%b rev=%0d exp cnt=10 ud=1 turn=0 rev=1",
               cnt, ud, turn, rev_cnt);
    end
    en = 1'b0; cnt_run = 1'b0;
    step(2);
    n_cmp++;
    if ({ud, turn, rev_cnt} !== {2'b10, 8'd1}) begin
      n_bad++;
      $display("FAIL pause_en0 got ud=%b turn=%b rev=%0d exp ud=1 turn=0 rev=1", ud, turn, rev_cnt);
    end
    en = 1'b1; mode = 2'b11;
    step(1);
    n_cmp++;
    if ({ud, turn} !== 2'b10) begin
      n_bad++;
      $display("FAIL pause_hold got ud=%b turn=%b exp ud=1 turn=0", ud, turn);
    end
    mode = 2'b10; cnt_run = 1'b1;
    step(1);
    n_cmp++;
    if ({cnt, ud, turn} !== {4'd9, 2'b00}) begin
      n_bad++;
      $display("FAIL resume_entry got cnt=%0d ud=%b turn=%b exp cnt=9 ud=0 turn=0", cnt, ud, turn);
    end
    step(1);
    n_cmp++;
    if ({cnt, ud, rev_cnt} !== {4'd10, 1'b0, 8'd1}) begin
      n_bad++;
      $display("FAIL resume_climb got cnt=%0d ud=%b rev=%0d exp cnt=10 ud=0 rev=1", cnt, ud, rev_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_up_only();
    test_down_only();
    test_err_limits();
    test_saturate_clr();
    test_async_reset();
    test_pause_resume();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
